// File: rtl/md_hilo_ctrl.sv
// md_hilo_ctrl: EX-stage multiply/divide scheduler and HI/LO register owner.
// Sequences a pipelined multiplier and an iterative divider (start/ready/annul),
// raises the EX stall request while an operation is in flight, and retires
// results into HI/LO.
// Optional feature macro: MD_HILO_BYPASS_EN -- when defined, an MTHI/MTLO
// accepted this cycle is forwarded combinationally onto hi_rdata/lo_rdata.
module md_hilo_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_src1,
  input  logic [31:0] md_src2,
  input  logic        adv,
  input  logic        flush,
  output logic        stallreq,
  output logic        md_done,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic [31:0] hi_rdata,
  output logic [31:0] lo_rdata
);

  localparam int CW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_RUN  = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t        state_r;
  logic [31:0]   hi_r;
  logic [31:0]   lo_r;
  logic [31:0]   opa_r;
  logic [31:0]   opb_r;
  logic          sign_r;
  logic [CW-1:0] cnt_r;
  logic          done_first_r;

  logic          is_mul_s;
  logic          is_div_s;
  logic          mthi_acc_s;
  logic          mtlo_acc_s;

  // Decode the EX operation and qualify HI/LO moves (only accepted in IDLE, not on flush/reset).
  always_comb begin
    is_mul_s   = (md_op == OP_MULT) || (md_op == OP_MULTU);
    is_div_s   = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    mthi_acc_s = (state_r == IDLE) && (md_op == OP_MTHI) && !flush && !rst;
    mtlo_acc_s = (state_r == IDLE) && (md_op == OP_MTLO) && !flush && !rst;
  end

  // Handshake and status outputs; the IDLE-cycle stall must be combinational so EX holds immediately.
  always_comb begin
    stallreq  = !rst && (((state_r == IDLE) && (is_mul_s || is_div_s)) ||
                         (state_r == MUL_WAIT) || (state_r == DIV_RUN));
    md_done   = !rst && (((state_r == DONE) && done_first_r) || mthi_acc_s || mtlo_acc_s);
    div_annul = !rst && flush && (state_r == DIV_RUN);
  end

  // Unit operand buses come from the latches only while that unit is in use, else zero.
  always_comb begin
    if (state_r == MUL_WAIT) begin
      mul_signed = sign_r;
      mul_ina    = opa_r;
      mul_inb    = opb_r;
    end else begin
      mul_signed = 1'b0;
      mul_ina    = 32'd0;
      mul_inb    = 32'd0;
    end
    if (state_r == DIV_RUN) begin
      div_start  = 1'b1;
      div_signed = sign_r;
      div_op1    = opa_r;
      div_op2    = opb_r;
    end else begin
      div_start  = 1'b0;
      div_signed = 1'b0;
      div_op1    = 32'd0;
      div_op2    = 32'd0;
    end
  end

`ifdef MD_HILO_BYPASS_EN
  // HI/LO read port with same-cycle forwarding of an accepted MTHI/MTLO.
  always_comb begin
    hi_rdata = mthi_acc_s ? md_src1 : hi_r;
    lo_rdata = mtlo_acc_s ? md_src1 : lo_r;
  end
`else
  // HI/LO read port straight from the architectural registers.
  always_comb begin
    hi_rdata = hi_r;
    lo_rdata = lo_r;
  end
`endif

  // Scheduler FSM, operand latches and HI/LO registers; flush beats any completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      hi_r         <= 32'd0;
      lo_r         <= 32'd0;
      opa_r        <= 32'd0;
      opb_r        <= 32'd0;
      sign_r       <= 1'b0;
      cnt_r        <= '0;
      done_first_r <= 1'b0;
    end else if (flush) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      done_first_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_first_r <= 1'b0;
          case (md_op)
            OP_MULT, OP_MULTU: begin
              opa_r   <= md_src1;
              opb_r   <= md_src2;
              sign_r  <= (md_op == OP_MULT);
              cnt_r   <= CW'(MUL_LAT);
              state_r <= MUL_WAIT;
            end
            OP_DIV, OP_DIVU: begin
              if (md_src2 != 32'd0) begin
                opa_r   <= md_src1;
                opb_r   <= md_src2;
                sign_r  <= (md_op == OP_DIV);
                state_r <= DIV_RUN;
              end else begin
                // Divide by zero never reaches the divider: fixed architectural result.
                hi_r         <= md_src1;
                lo_r         <= 32'hFFFF_FFFF;
                done_first_r <= 1'b1;
                state_r      <= DONE;
              end
            end
            OP_MTHI: hi_r <= md_src1;
            OP_MTLO: lo_r <= md_src1;
            default: state_r <= IDLE;
          endcase
        end
        MUL_WAIT: begin
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            hi_r         <= mul_result[63:32];
            lo_r         <= mul_result[31:0];
            done_first_r <= 1'b1;
            state_r      <= DONE;
          end else begin
            state_r <= MUL_WAIT;
          end
        end
        DIV_RUN: begin
          if (div_ready) begin
            hi_r         <= div_result[63:32];
            lo_r         <= div_result[31:0];
            done_first_r <= 1'b1;
            state_r      <= DONE;
          end else begin
            state_r <= DIV_RUN;
          end
        end
        DONE: begin
          // The instruction is still presented here; never restart it, just wait to leave.
          done_first_r <= 1'b0;
          if (adv) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Self-checking bench for md_hilo_ctrl: table of operations with a result
// scoreboard, plus hand sequences for flush, flush-at-completion and reset.
module tb_md_hilo_ctrl;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  md_op;
  logic [31:0] md_src1, md_src2;
  logic        adv, flush;
  logic        stallreq, md_done;
  logic        mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_annul;
  logic [31:0] div_op1, div_op2;
  logic        div_ready;
  logic [63:0] div_result;
  logic [31:0] hi_rdata, lo_rdata;

  int checks = 0;
  int errors = 0;

  md_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .md_op(md_op), .md_src1(md_src1), .md_src2(md_src2),
    .adv(adv), .flush(flush), .stallreq(stallreq), .md_done(md_done),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_op1(div_op1), .div_op2(div_op2),
    .div_annul(div_annul), .div_ready(div_ready), .div_result(div_result),
    .hi_rdata(hi_rdata), .lo_rdata(lo_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mul_model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y;
    x = s ? {{32{a[31]}}, a} : {32'd0, a};
    y = s ? {{32{b[31]}}, b} : {32'd0, b};
    return x * y;
  endfunction

  function automatic logic [63:0] div_model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Multiplier model: one register stage behind the operand bus.
  always @(posedge clk) mul_result <= mul_model(mul_signed, mul_ina, mul_inb);

  // Divider model: ready pulse DIV_LAT+1 cycles after start, cleared by annul/reset.
  int dcnt;
  always @(posedge clk) begin
    if (rst || div_annul || !div_start) begin
      dcnt <= 0;
      div_ready <= 1'b0;
    end else if (div_ready) begin
      div_ready <= 1'b0;
    end else if (dcnt == DIV_LAT) begin
      div_ready  <= 1'b1;
      div_result <= div_model(div_signed, div_op1, div_op2);
    end else begin
      dcnt <= dcnt + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } vec_t;

  vec_t        vecs[8];
  logic [63:0] sb[$];
  logic [31:0] hi_m, lo_m;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    int   cyc, stalls;
    logic done_seen, start_seen, is_mt, is_mul, is_div;
    logic [63:0] exp;
    is_mt  = (v.op == 3'd5) || (v.op == 3'd6);
    is_mul = (v.op == 3'd1) || (v.op == 3'd2);
    is_div = (v.op == 3'd3) || (v.op == 3'd4);
    step();
    md_op = v.op; md_src1 = v.a; md_src2 = v.b; adv = 1'b0; flush = 1'b0;
    sb.push_back({v.hi, v.lo});
    cyc = 0; stalls = 0; done_seen = 1'b0; start_seen = 1'b0;
    while (!done_seen && cyc < 50) begin
      @(negedge clk);
      if (div_start) start_seen = 1'b1;
      if (cyc == 1 && is_mul) begin
        chk("mul_ina", {32'd0, mul_ina}, {32'd0, v.a});
        chk("mul_inb", {32'd0, mul_inb}, {32'd0, v.b});
      end
      if (cyc == 1 && is_div && v.b != 32'd0) begin
        chk("div_start", {63'd0, div_start}, 64'd1);
        chk("div_op1", {32'd0, div_op1}, {32'd0, v.a});
      end
      if (md_done) begin
        done_seen = 1'b1;
        chk("stall_at_done", {63'd0, stallreq}, 64'd0);
      end else begin
        if (stallreq) stalls++;
        step();
        cyc++;
      end
    end
    chk("done_seen", {63'd0, done_seen}, 64'd1);
    chk("stall_cycles", 64'(stalls), 64'(v.stalls));
    if (is_div && v.b == 32'd0) chk("div_start_on_zero", {63'd0, start_seen}, 64'd0);
    exp = sb.pop_front();
    if (is_mt) begin
`ifdef MD_HILO_BYPASS_EN
      chk("mt_same_cycle_hi", {32'd0, hi_rdata}, {32'd0, exp[63:32]});
      chk("mt_same_cycle_lo", {32'd0, lo_rdata}, {32'd0, exp[31:0]});
`else
      chk("mt_same_cycle_hi", {32'd0, hi_rdata}, {32'd0, hi_m});
      chk("mt_same_cycle_lo", {32'd0, lo_rdata}, {32'd0, lo_m});
`endif
      step();
      md_op = 3'd0;
      @(negedge clk);
      chk("hilo", {hi_rdata, lo_rdata}, exp);
      chk("mt_done_once", {63'd0, md_done}, 64'd0);
    end else begin
      chk("hilo", {hi_rdata, lo_rdata}, exp);
      for (int k = 0; k < 3; k++) begin
        step();
        @(negedge clk);
        chk("done_hold_pulse", {63'd0, md_done}, 64'd0);
        chk("done_hold_stall", {63'd0, stallreq}, 64'd0);
        chk("done_hold_restart", {62'd0, div_start, (mul_ina != 32'd0)}, 64'd0);
      end
      step();
      adv = 1'b1;
      step();
      adv = 1'b0; md_op = 3'd0;
    end
    hi_m = exp[63:32];
    lo_m = exp[31:0];
  endtask

  initial begin
    logic done_any;
    vecs[0] = '{3'd1, 32'hFFFF_FFFE, 32'd3,      32'hFFFF_FFFF, 32'hFFFF_FFFA, 3};
    vecs[1] = '{3'd2, 32'hFFFF_FFFE, 32'd3,      32'h0000_0002, 32'hFFFF_FFFA, 3};
    vecs[2] = '{3'd3, 32'hFFFF_FFF9, 32'd2,      32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT + 3};
    vecs[3] = '{3'd4, 32'd100,       32'd7,      32'h0000_0002, 32'h0000_000E, DIV_LAT + 3};
    vecs[4] = '{3'd4, 32'h0000_1234, 32'd0,      32'h0000_1234, 32'hFFFF_FFFF, 1};
    vecs[5] = '{3'd1, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 3};
    vecs[6] = '{3'd6, 32'hA5A5_A5A5, 32'd0,      32'hFFFF_FFFF, 32'hA5A5_A5A5, 0};
    vecs[7] = '{3'd5, 32'h1234_5678, 32'd0,      32'h1234_5678, 32'hA5A5_A5A5, 0};

    rst = 1'b1; md_op = 3'd0; md_src1 = 32'd0; md_src2 = 32'd0; adv = 1'b0; flush = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_hilo", {hi_rdata, lo_rdata}, 64'd0);
    chk("rst_ctrl", {60'd0, stallreq, md_done, div_start, div_annul}, 64'd0);
    chk("rst_ops", {mul_ina, div_op1}, 64'd0);
    step();
    rst = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Flush in DIV_RUN cycle 5: annul pulse, no result, HI/LO kept.
    step();
    md_op = 3'd3; md_src1 = 32'd50; md_src2 = 32'd7;
    for (int i = 0; i < 5; i++) step();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_div_annul", {63'd0, div_annul}, 64'd1);
    step();
    flush = 1'b0; md_op = 3'd0;
    @(negedge clk);
    chk("flush_div_idle", {61'd0, stallreq, div_start, div_annul}, 64'd0);
    done_any = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      @(negedge clk);
      if (md_done) done_any = 1'b1;
    end
    chk("flush_div_no_done", {63'd0, done_any}, 64'd0);
    chk("flush_div_hilo", {hi_rdata, lo_rdata}, {hi_m, lo_m});

    // Flush together with MTLO in IDLE: write suppressed.
    step();
    md_op = 3'd6; md_src1 = 32'h0BAD_F00D; flush = 1'b1;
    @(negedge clk);
    chk("flush_mt_done", {63'd0, md_done}, 64'd0);
    chk("flush_mt_lo_now", {32'd0, lo_rdata}, {32'd0, lo_m});
    step();
    md_op = 3'd0; flush = 1'b0;
    @(negedge clk);
    chk("flush_mt_lo", {32'd0, lo_rdata}, {32'd0, lo_m});

    // Flush in the MUL completion cycle discards the result.
    step();
    md_op = 3'd1; md_src1 = 32'd5; md_src2 = 32'd6;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; md_op = 3'd0;
    @(negedge clk);
    chk("flush_mul_hilo", {hi_rdata, lo_rdata}, {hi_m, lo_m});
    chk("flush_mul_ctrl", {62'd0, stallreq, md_done}, 64'd0);
    step();
    @(negedge clk);
    chk("flush_mul_no_done", {63'd0, md_done}, 64'd0);

    // Reset mid-divide (with flush): no annul, HI/LO cleared.
    step();
    md_op = 3'd4; md_src1 = 32'd50; md_src2 = 32'd7;
    step();
    step();
    rst = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("rst_mid_annul", {63'd0, div_annul}, 64'd0);
    step();
    rst = 1'b0; flush = 1'b0; md_op = 3'd0;
    @(negedge clk);
    chk("rst_mid_hilo", {hi_rdata, lo_rdata}, 64'd0);
    chk("rst_mid_ctrl", {62'd0, stallreq, div_start}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
